// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pad-bank arbiter.
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    TURN   = 2'd3
  } arb_state_e;

  localparam int TURN_W = 4;
  localparam int HOLD_W = 16;

  // Requester indices, also the encoding of the round-robin pointer.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Grant decision from an idle bus: a lone requester wins, a tie goes to rr_ptr.
  function automatic arb_state_e pick_grant(input logic req0, input logic req1,
                                            input logic rr_ptr);
    arb_state_e nxt;
    nxt = IDLE;
    if (req0 && req1) begin
      nxt = (rr_ptr == REQ1) ? GRANT1 : GRANT0;
    end else if (req0) begin
      nxt = GRANT0;
    end else if (req1) begin
      nxt = GRANT1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/uio_pad_mux.sv
// Registered 2:1 pad selector. Drives a requester's data/enables only while
// that requester keeps ownership across the edge, so pad_oe is already zero
// in the first cycle after its grant falls.
module uio_pad_mux
  import uio_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  arb_state_e state,
  input  arb_state_e state_nxt,
  input  logic [7:0] out0,
  input  logic [7:0] oe0,
  input  logic [7:0] out1,
  input  logic [7:0] oe1,
  input  logic [7:0] pad_in,
  output logic [7:0] pad_out,
  output logic [7:0] pad_oe,
  output logic [7:0] bus_in
);

  // Pad output/enable register and the input capture register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_out <= 8'h00;
      pad_oe  <= 8'h00;
      bus_in  <= 8'h00;
    end else begin
      bus_in <= pad_in;
      if (state == GRANT0 && state_nxt == GRANT0) begin
        pad_out <= out0;
        pad_oe  <= oe0;
      end else if (state == GRANT1 && state_nxt == GRANT1) begin
        pad_out <= out1;
        pad_oe  <= oe1;
      end else begin
        pad_out <= 8'h00;
        pad_oe  <= 8'h00;
      end
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter for the shared uio pad bank with a forced turnaround
// (all enables off) on every ownership change and optional hold-time preemption.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int TURN_CYCLES = 2,
  parameter int MAX_HOLD    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [7:0] out0,
  input  logic [7:0] oe0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [7:0] out1,
  input  logic [7:0] oe1,
  output logic       gnt1,
  input  logic [7:0] pad_in,
  output logic [7:0] pad_out,
  output logic [7:0] pad_oe,
  output logic [7:0] bus_in
);

  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state, state_nxt;
  logic              rr_ptr, rr_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [TURN_W-1:0] turn_cnt, turn_nxt;
  logic              preempt0, preempt1;

  // Hold limit reached while the other side waits: give the bus up.
  assign preempt0 = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && req1;
  assign preempt1 = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && req0;

  // FSM, counters, pointer and registered grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= REQ0;
      hold_cnt <= '0;
      turn_cnt <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      hold_cnt <= hold_nxt;
      turn_cnt <= turn_nxt;
      gnt0     <= (state_nxt == GRANT0);
      gnt1     <= (state_nxt == GRANT1);
    end
  end

  // Next-state decision; releasing a grant always passes through TURN.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    hold_nxt  = hold_cnt;
    turn_nxt  = turn_cnt;
    unique case (state)
      IDLE: begin
        state_nxt = pick_grant(req0, req1, rr_ptr);
      end
      GRANT0: begin
        if (hold_cnt != '1) hold_nxt = hold_cnt + HOLD_W'(1);
        if (!req0 || preempt0) begin
          state_nxt = TURN;
          rr_nxt    = REQ1;
          hold_nxt  = '0;
        end
      end
      GRANT1: begin
        if (hold_cnt != '1) hold_nxt = hold_cnt + HOLD_W'(1);
        if (!req1 || preempt1) begin
          state_nxt = TURN;
          rr_nxt    = REQ0;
          hold_nxt  = '0;
        end
      end
      TURN: begin
        if (turn_cnt == TURN_LAST) begin
          turn_nxt  = '0;
          state_nxt = pick_grant(req0, req1, rr_ptr);
        end else begin
          turn_nxt = turn_cnt + TURN_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  uio_pad_mux u_pad_mux (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (state),
    .state_nxt (state_nxt),
    .out0      (out0),
    .oe0       (oe0),
    .out1      (out1),
    .oe1       (oe1),
    .pad_in    (pad_in),
    .pad_out   (pad_out),
    .pad_oe    (pad_oe),
    .bus_in    (bus_in)
  );

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: one default instance (MAX_HOLD=0) and
// one preempting instance (MAX_HOLD=8) sharing the same stimulus.
module tb_uio_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] out0 = '0, oe0 = '0, out1 = '0, oe1 = '0, pad_in = '0;

  logic       gnt0, gnt1;
  logic [7:0] pad_out, pad_oe, bus_in;
  logic       gnt0_p, gnt1_p;
  logic [7:0] pad_out_p, pad_oe_p, bus_in_p;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uio_bus_arbiter #(.TURN_CYCLES(2), .MAX_HOLD(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .out0(out0), .oe0(oe0), .gnt0(gnt0),
    .req1(req1), .out1(out1), .oe1(oe1), .gnt1(gnt1),
    .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe), .bus_in(bus_in)
  );

  uio_bus_arbiter #(.TURN_CYCLES(2), .MAX_HOLD(8)) dut_p (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .out0(out0), .oe0(oe0), .gnt0(gnt0_p),
    .req1(req1), .out1(out1), .oe1(oe1), .gnt1(gnt1_p),
    .pad_in(pad_in), .pad_out(pad_out_p), .pad_oe(pad_oe_p), .bus_in(bus_in_p)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 0; req1 = 0; out0 = 0; oe0 = 0; out1 = 0; oe1 = 0; pad_in = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1; req1 = 1; oe0 = 8'hFF; out0 = 8'hFF; oe1 = 8'hFF; out1 = 8'hFF;
    pad_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({gnt0, gnt1} !== 2'b00) begin
        n_bad++; $display("FAIL reset_gnt cyc%0d: got %b want 00", i, {gnt0, gnt1});
      end
      n_cmp++;
      if (pad_oe !== 8'h00 || pad_out !== 8'h00) begin
        n_bad++; $display("FAIL reset_pad cyc%0d: oe=%h out=%h want 00/00", i, pad_oe, pad_out);
      end
      n_cmp++;
      if (bus_in !== 8'h00) begin
        n_bad++; $display("FAIL reset_bus_in cyc%0d: got %h want 00", i, bus_in);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    req0 = 1; out0 = 8'hA5; oe0 = 8'h0F;
    tick();
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_bad++; $display("FAIL single_gnt_latency: got %b want 10", {gnt0, gnt1});
    end
    n_cmp++;
    if (pad_oe !== 8'h00) begin
      n_bad++; $display("FAIL single_oe_first: got %h want 00", pad_oe);
    end
    tick();
    n_cmp++;
    if (pad_out !== 8'hA5 || pad_oe !== 8'h0F) begin
      n_bad++; $display("FAIL single_pad: out=%h oe=%h want a5/0f", pad_out, pad_oe);
    end
    // Release then immediately re-request: turnaround is still paid.
    req0 = 0;
    tick();
    req0 = 1;
    n_cmp++;
    if (gnt0 !== 1'b0 || pad_oe !== 8'h00) begin
      n_bad++; $display("FAIL rereq_turn1: gnt0=%b oe=%h want 0/00", gnt0, pad_oe);
    end
    tick();
    n_cmp++;
    if (gnt0 !== 1'b0 || pad_oe !== 8'h00) begin
      n_bad++; $display("FAIL rereq_turn2: gnt0=%b oe=%h want 0/00", gnt0, pad_oe);
    end
    tick();
    n_cmp++;
    if (gnt0 !== 1'b1) begin
      n_bad++; $display("FAIL rereq_grant: gnt0=%b want 1", gnt0);
    end
  endtask

  task automatic test_round_robin();
    logic owner;
    do_reset();
    oe0 = 8'hFF; oe1 = 8'hFF; out0 = 8'h11; out1 = 8'h22;
    req0 = 1; req1 = 1;
    tick();
    for (int r = 0; r < 4; r++) begin
      owner = r[0];
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if ({gnt0, gnt1} !== (owner ? 2'b01 : 2'b10)) begin
          n_bad++; $display("FAIL rr_gnt r%0d c%0d: got %b want owner %0d", r, c, {gnt0, gnt1}, owner);
        end
        if (c >= 1) begin
          n_cmp++;
          if (pad_oe !== 8'hFF || pad_out !== (owner ? 8'h22 : 8'h11)) begin
            n_bad++; $display("FAIL rr_pad r%0d c%0d: oe=%h out=%h", r, c, pad_oe, pad_out);
          end
        end
        if (c == 2) begin
          if (owner) req1 = 0; else req0 = 0;
        end
        tick();
      end
      for (int t = 0; t < 2; t++) begin
        if (t == 0) begin
          req0 = 1; req1 = 1;
        end
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b00 || pad_oe !== 8'h00) begin
          n_bad++; $display("FAIL rr_turn r%0d t%0d: gnt=%b oe=%h want 00/00", r, t, {gnt0, gnt1}, pad_oe);
        end
        tick();
      end
    end
  endtask

  task automatic test_preempt();
    do_reset();
    req0 = 1; oe0 = 8'hFF; out0 = 8'h5A; oe1 = 8'hF0; out1 = 8'h0F;
    tick();
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (cyc == 2) req1 = 1;
      n_cmp++;
      if (gnt0_p !== (cyc <= 8) || gnt1_p !== (cyc >= 11)) begin
        n_bad++; $display("FAIL preempt_gnt cyc%0d: got %b%b want %b%b", cyc, gnt0_p, gnt1_p,
                          (cyc <= 8), (cyc >= 11));
      end
      if (cyc == 9 || cyc == 10) begin
        n_cmp++;
        if (pad_oe_p !== 8'h00) begin
          n_bad++; $display("FAIL preempt_turn_oe cyc%0d: got %h want 00", cyc, pad_oe_p);
        end
      end
      n_cmp++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
        n_bad++; $display("FAIL nohold_gnt cyc%0d: got %b%b want 10", cyc, gnt0, gnt1);
      end
      tick();
    end
    n_cmp++;
    if (pad_oe_p !== 8'hF0 || pad_out_p !== 8'h0F) begin
      n_bad++; $display("FAIL preempt_pad1: oe=%h out=%h want f0/0f", pad_oe_p, pad_out_p);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req1 = 1; oe1 = 8'hFF; out1 = 8'h5A;
    tick();
    tick();
    n_cmp++;
    if (gnt1 !== 1'b1 || pad_oe !== 8'hFF) begin
      n_bad++; $display("FAIL midrst_pre: gnt1=%b oe=%h want 1/ff", gnt1, pad_oe);
    end
    req0 = 1;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (gnt1 !== 1'b0 || gnt0 !== 1'b0 || pad_oe !== 8'h00) begin
      n_bad++; $display("FAIL midrst_async: gnt=%b%b oe=%h want 00/00", gnt0, gnt1, pad_oe);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_bad++; $display("FAIL midrst_rr: got %b want 10", {gnt0, gnt1});
    end
  endtask

  task automatic test_bus_in();
    pad_in = 8'h3C;
    tick();
    pad_in = 8'hC3;
    n_cmp++;
    if (bus_in !== 8'h3C) begin
      n_bad++; $display("FAIL bus_in_a: got %h want 3c", bus_in);
    end
    tick();
    n_cmp++;
    if (bus_in !== 8'hC3) begin
      n_bad++; $display("FAIL bus_in_b: got %h want c3", bus_in);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_reset_mid_grant();
    test_bus_in();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
